wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port of the RISC-V core.
- Shares the port between two sources: the in-order pipeline writeback (MEM/WB stage outputs) and a long-latency unit (multi-cycle mul/div) that completes out of band.
- Pipeline writeback has priority. Long-latency results wait in a small in-block FIFO.
- If a FIFO head waits too long, the block stalls the pipeline for one cycle to drain it.

Parameters:
XLEN, 64, register/data width
DEPTH, 2, long-latency result FIFO entries (power of 2, >=2)
MAX_WAIT, 4, cycles a FIFO head may be blocked before a forced drain (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wb_reg_write  in  1  MEM/WB RegWrite
wb_mem_to_reg  in  1  MEM/WB MemToReg: 1 selects wb_read_data, 0 selects wb_alu_result
wb_read_data  in  XLEN  MEM/WB load data
wb_alu_result  in  XLEN  MEM/WB ALU result
wb_rd  in  5  MEM/WB destination register
ll_valid  in  1  long-latency result valid
ll_ready  out  1  FIFO can accept; high when FIFO not full
ll_rd  in  5  long-latency destination register
ll_data  in  XLEN  long-latency result
rf_we  out  1  register-file write enable, registered
rf_waddr  out  5  register-file write address, registered
rf_wdata  out  XLEN  register-file write data, registered
pipe_stall  out  1  freezes IF..MEM/WB for this cycle, registered
fifo_count  out  log2(DEPTH)+1  occupancy, for debug and scoreboard

Behaviour:
- Reset (reset=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0.
  - FIFO emptied, fifo_count=0, wait_cnt=0, state=IDLE.
  - ll_ready=1 once reset deasserts.
  - Reset mid-operation discards buffered results with no write.
- Accept: FIFO push when ll_valid && ll_ready on a rising edge.
  - Entries with ll_rd==0 are accepted and dropped; they are never pushed.
- Pipeline write request: pw = wb_reg_write && wb_rd!=0 && !pipe_stall.
  - Data = wb_mem_to_reg ? wb_read_data : wb_alu_result.
- Latency: the port winner at edge N appears on rf_* after edge N (1 cycle). rf_we is low in any cycle with no winner.
- States:
  - IDLE: FIFO empty.
    - pw -> write pipeline.
    - Next state is PEND if a push occurs, else IDLE.
  - PEND: FIFO non-empty.
    - If pw: write pipeline, wait_cnt++.
    - Else: pop head, write it, wait_cnt=0.
    - When wait_cnt reaches MAX_WAIT with the head still blocked, register pipe_stall=1 and go to FORCE.
    - Go to IDLE when the FIFO becomes empty with no push in the same cycle.
  - FORCE: pipe_stall=1 for exactly one cycle.
    - pw is ignored; MEM/WB holds its contents under stall and re-presents them next cycle.
    - Pop head, write it, wait_cnt=0, pipe_stall=0.
    - Next state is PEND if FIFO still non-empty, else IDLE.
- Simultaneous push and pop:
  - Both are allowed in the same cycle; count is unchanged.
  - When full, push is blocked by ll_ready=0, even if a pop occurs that cycle. ll_ready is purely a function of the registered count.
- WAW squash: when the pipeline writes rd=R, every FIFO entry with rd==R is invalidated. Invalid entries are popped without a write.
  - Invalidated entries still occupy slots until popped.
  - A pop of an invalid head consumes the cycle's pop slot and resets wait_cnt.
- Ordering: FIFO entries write back in arrival order. The pipeline never waits on the FIFO except in FORCE.
- Pointers wrap modulo DEPTH.
- wait_cnt saturates at MAX_WAIT.

Test Plan:
1. Reset low mid-drain with 2 entries queued -> all outputs 0, fifo_count=0, no rf_we after release.
2. wb_reg_write=1, rd=5, mem_to_reg=1, read_data=0xAA, alu=0xBB -> next cycle rf_we=1, waddr=5, wdata=0xAA. Repeat with rd=0 -> rf_we=0.
3. ll push (rd=7, data=0x11) with pipeline idle -> rf_we=1, waddr=7, wdata=0x11 on the cycle after the pop; fifo_count returns to 0.
4. Continuous pipeline writes plus one ll push, MAX_WAIT=4:
   - pipe_stall=1 for exactly one cycle after 4 blocked cycles.
   - That cycle writes the ll entry; the held pipeline write lands next cycle.
5. Two ll pushes back-to-back with pipeline busy -> ll_ready=0 at count 2; a third ll_valid is held. When the pipeline idles, writes drain in order.
6. ll push rd=9, then pipeline writes rd=9 before drain -> the entry is squashed; only the pipeline value appears on rf_wdata for x9.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Owns the single register-file write port. The in-order pipeline writeback
// always wins the port. Long-latency (mul/div) results are parked in a small
// FIFO and drained in cycles where the pipeline does not write. If the FIFO
// head is blocked for MAX_WAIT consecutive pipeline writes, the block stalls
// the pipeline for one cycle and drains the head.
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   wb_*                MEM/WB writeback request (reg_write, mem_to_reg, data, rd)
//   ll_valid/ll_ready   long-latency result handshake; ll_rd/ll_data payload
//   rf_we/waddr/wdata   registered register-file write port
//   pipe_stall          registered one-cycle freeze of IF..MEM/WB
//   fifo_count          FIFO occupancy (debug)
//
// state   | meaning
// S_IDLE  | FIFO empty; port serves the pipeline only
// S_PEND  | FIFO non-empty; pipeline wins, head drains in free cycles
// S_FORCE | pipeline frozen this cycle; head drains unconditionally

module wb_port_arbiter #(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_reg_write,
    input  logic                   wb_mem_to_reg,
    input  logic [XLEN-1:0]        wb_read_data,
    input  logic [XLEN-1:0]        wb_alu_result,
    input  logic [4:0]             wb_rd,
    input  logic                   ll_valid,
    output logic                   ll_ready,
    input  logic [4:0]             ll_rd,
    input  logic [XLEN-1:0]        ll_data,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic                   pipe_stall,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [4:0]        fifo_rd_q   [DEPTH];
    logic [XLEN-1:0]   fifo_data_q [DEPTH];
    logic [DEPTH-1:0]  fifo_vld_q, fifo_vld_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [WW-1:0]     wait_inc;

    logic              stall_q, stall_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    logic              push;
    logic              pop;
    logic              pw;
    logic [XLEN-1:0]   pw_data;
    logic [4:0]        head_rd;
    logic [XLEN-1:0]   head_data;
    logic              head_vld;

    // Ready depends only on registered occupancy, so a pop in the same cycle
    // never opens a slot for a push while full.
    assign ll_ready  = (count_q != CW'(DEPTH));
    // x0 results have no architectural effect and are dropped at the door.
    assign push      = ll_valid && ll_ready && (ll_rd != 5'd0);
    assign pw        = wb_reg_write && (wb_rd != 5'd0) && !stall_q;
    assign pw_data   = wb_mem_to_reg ? wb_read_data : wb_alu_result;

    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];
    assign head_vld  = fifo_vld_q[rd_ptr_q];

    assign wait_inc  = (wait_q >= WW'(MAX_WAIT)) ? WW'(MAX_WAIT) : wait_q + WW'(1);

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        wait_d     = wait_q;
        stall_d    = 1'b0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (pw) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = wb_rd;
                    rf_wdata_d = pw_data;
                end
            end
            S_PEND: begin
                if (pw) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = wb_rd;
                    rf_wdata_d = pw_data;
                    wait_d     = wait_inc;
                    if (wait_inc == WW'(MAX_WAIT)) begin
                        stall_d = 1'b1;
                    end
                end else begin
                    pop    = 1'b1;
                    wait_d = '0;
                    if (head_vld) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = head_rd;
                        rf_wdata_d = head_data;
                    end
                end
            end
            S_FORCE: begin
                // pw is already gated off by the registered stall.
                pop    = 1'b1;
                wait_d = '0;
                if (head_vld) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = head_rd;
                    rf_wdata_d = head_data;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        if (stall_d) begin
            state_d = S_FORCE;
        end else if (count_d != '0) begin
            state_d = S_PEND;
        end else begin
            state_d = S_IDLE;
        end
    end

    // WAW squash: a pipeline write makes every queued result for the same rd
    // stale. A result arriving in the same cycle also comes from an older
    // instruction, so it is queued already invalid.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_vld_d[i] = fifo_vld_q[i] && !(pw && (fifo_rd_q[i] == wb_rd));
        end
        if (push) begin
            fifo_vld_d[wr_ptr_q] = !(pw && (ll_rd == wb_rd));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fifo_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            fifo_vld_q <= fifo_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Payload storage needs no reset; the valid bits and count qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ll_rd;
            fifo_data_q[wr_ptr_q] <= ll_data;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign pipe_stall = stall_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model, per-cycle compare,
// and directed scenarios with literal expectations.

module tb_wb_port_arbiter;

    localparam int XLEN     = 64;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wb_reg_write = 1'b0;
    logic            wb_mem_to_reg = 1'b0;
    logic [XLEN-1:0] wb_read_data = '0;
    logic [XLEN-1:0] wb_alu_result = '0;
    logic [4:0]      wb_rd = '0;
    logic            ll_valid = 1'b0;
    logic            ll_ready;
    logic [4:0]      ll_rd = '0;
    logic [XLEN-1:0] ll_data = '0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            pipe_stall;
    logic [1:0]      fifo_count;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_reg_write (wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_read_data (wb_read_data),
        .wb_alu_result(wb_alu_result),
        .wb_rd        (wb_rd),
        .ll_valid     (ll_valid),
        .ll_ready     (ll_ready),
        .ll_rd        (ll_rd),
        .ll_data      (ll_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pipe_stall   (pipe_stall),
        .fifo_count   (fifo_count)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: queue of pending results, a blocked-cycle counter and
    // a pending-stall flag; the write-port outcome of each edge follows the
    // arbitration rules directly.
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
        bit          v;
    } ent_t;

    ent_t        mq[$];
    int          m_wait;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;

    always @(posedge clk or negedge reset) begin : model
        int   sz;
        bit   can_push;
        bit   pwr;
        bit   was_stall;
        ent_t e;
        if (!reset) begin
            mq.delete();
            m_wait  = 0;
            m_stall = 1'b0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            sz        = mq.size();
            can_push  = ll_valid && (sz < DEPTH) && (ll_rd != 5'd0);
            pwr       = wb_reg_write && (wb_rd != 5'd0) && !m_stall;
            was_stall = m_stall;
            m_stall   = 1'b0;
            m_we      = 1'b0;
            if (was_stall) begin
                if (sz > 0) begin
                    e = mq.pop_front();
                    if (e.v) begin
                        m_we = 1'b1; m_waddr = e.rd; m_wdata = e.d;
                    end
                end
                m_wait = 0;
            end else if (pwr) begin
                m_we    = 1'b1;
                m_waddr = wb_rd;
                m_wdata = wb_mem_to_reg ? wb_read_data : wb_alu_result;
                foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].v = 1'b0;
                if (sz > 0) begin
                    if (m_wait < MAX_WAIT) m_wait++;
                    if (m_wait == MAX_WAIT) m_stall = 1'b1;
                end
            end else if (sz > 0) begin
                e = mq.pop_front();
                if (e.v) begin
                    m_we = 1'b1; m_waddr = e.rd; m_wdata = e.d;
                end
                m_wait = 0;
            end
            if (can_push) begin
                e.rd = ll_rd;
                e.d  = ll_data;
                e.v  = !(pwr && (wb_rd == ll_rd));
                mq.push_back(e);
            end
            if (mq.size() == 0) m_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_rf_we", 64'(rf_we), 64'(m_we));
            if (m_we) begin
                chk("cyc_rf_waddr", 64'(rf_waddr), 64'(m_waddr));
                chk("cyc_rf_wdata", rf_wdata, m_wdata);
            end
            chk("cyc_pipe_stall", 64'(pipe_stall), 64'(m_stall));
            chk("cyc_fifo_count", 64'(fifo_count), 64'(mq.size()));
            chk("cyc_ll_ready", 64'(ll_ready), 64'(mq.size() < DEPTH));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input bit we, input bit m2r, input logic [4:0] rd,
                        input logic [63:0] rdata, input logic [63:0] alu);
        wb_reg_write  = we;
        wb_mem_to_reg = m2r;
        wb_rd         = rd;
        wb_read_data  = rdata;
        wb_alu_result = alu;
    endtask

    task automatic ll(input bit v, input logic [4:0] rd, input logic [63:0] d);
        ll_valid = v;
        ll_rd    = rd;
        ll_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", rf_wdata, 64'd0);
        chk("rst_pipe_stall", 64'(pipe_stall), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        reset = 1'b1;
        step();
        chk("rst_ll_ready", 64'(ll_ready), 64'd1);

        // Pipeline writes: mem_to_reg select, rd=0 suppression, alu select.
        pipe(1, 1, 5'd5, 64'hAA, 64'hBB);
        step();
        chk("pw_we", 64'(rf_we), 64'd1);
        chk("pw_waddr", 64'(rf_waddr), 64'd5);
        chk("pw_wdata_mem", rf_wdata, 64'hAA);
        pipe(1, 1, 5'd0, 64'hAA, 64'hBB);
        step();
        chk("pw_rd0_we", 64'(rf_we), 64'd0);
        pipe(1, 0, 5'd6, 64'hAA, 64'hBB);
        step();
        chk("pw_wdata_alu", rf_wdata, 64'hBB);
        chk("pw_waddr6", 64'(rf_waddr), 64'd6);
        pipe(0, 0, 5'd0, 64'h0, 64'h0);

        // Single ll result, pipeline idle: push then drain next edge.
        ll(1, 5'd7, 64'h11);
        step();
        ll(0, 5'd0, 64'h0);
        chk("ll_count1", 64'(fifo_count), 64'd1);
        step();
        chk("ll_we", 64'(rf_we), 64'd1);
        chk("ll_waddr", 64'(rf_waddr), 64'd7);
        chk("ll_wdata", rf_wdata, 64'h11);
        chk("ll_count0", 64'(fifo_count), 64'd0);

        // ll rd=0 is dropped.
        ll(1, 5'd0, 64'h55);
        step();
        ll(0, 5'd0, 64'h0);
        chk("ll_rd0_count", 64'(fifo_count), 64'd0);
        step();
        chk("ll_rd0_we", 64'(rf_we), 64'd0);

        // Forced drain after MAX_WAIT blocked cycles.
        pipe(1, 0, 5'd1, 64'h0, 64'h101);
        ll(1, 5'd8, 64'h88);
        step();
        ll(0, 5'd0, 64'h0);
        chk("frc_count", 64'(fifo_count), 64'd1);
        for (int k = 2; k <= 5; k++) begin
            pipe(1, 0, 5'(k), 64'h0, 64'(256 + k));
            step();
            if (k < 5) chk("frc_no_stall", 64'(pipe_stall), 64'd0);
        end
        chk("frc_stall", 64'(pipe_stall), 64'd1);
        chk("frc_last_pw", 64'(rf_waddr), 64'd5);
        pipe(1, 0, 5'd6, 64'h0, 64'h106);
        step();
        chk("frc_ll_we", 64'(rf_we), 64'd1);
        chk("frc_ll_waddr", 64'(rf_waddr), 64'd8);
        chk("frc_ll_wdata", rf_wdata, 64'h88);
        chk("frc_stall_off", 64'(pipe_stall), 64'd0);
        step();
        chk("frc_held_waddr", 64'(rf_waddr), 64'd6);
        chk("frc_held_wdata", rf_wdata, 64'h106);
        pipe(0, 0, 5'd0, 64'h0, 64'h0);
        step();

        // Fill to DEPTH, third result held off, in-order drain.
        pipe(1, 0, 5'd13, 64'h0, 64'hD13);
        ll(1, 5'd10, 64'hA0);
        step();
        chk("full_count1", 64'(fifo_count), 64'd1);
        pipe(1, 0, 5'd14, 64'h0, 64'hD14);
        ll(1, 5'd11, 64'hB0);
        step();
        chk("full_count2", 64'(fifo_count), 64'd2);
        chk("full_not_ready", 64'(ll_ready), 64'd0);
        pipe(1, 0, 5'd15, 64'h0, 64'hD15);
        ll(1, 5'd12, 64'hC0);
        step();
        chk("full_held_count", 64'(fifo_count), 64'd2);
        pipe(0, 0, 5'd0, 64'h0, 64'h0);
        step();
        chk("drain0_waddr", 64'(rf_waddr), 64'd10);
        chk("drain0_wdata", rf_wdata, 64'hA0);
        chk("drain0_ready", 64'(ll_ready), 64'd1);
        step();
        ll(0, 5'd0, 64'h0);
        chk("drain1_waddr", 64'(rf_waddr), 64'd11);
        chk("drain1_wdata", rf_wdata, 64'hB0);
        chk("drain1_count", 64'(fifo_count), 64'd1);
        step();
        chk("drain2_waddr", 64'(rf_waddr), 64'd12);
        chk("drain2_wdata", rf_wdata, 64'hC0);
        chk("drain2_count", 64'(fifo_count), 64'd0);
        step();

        // WAW squash: queued x9 result is overwritten by the pipeline.
        pipe(1, 0, 5'd3, 64'h0, 64'h303);
        ll(1, 5'd9, 64'h99);
        step();
        ll(0, 5'd0, 64'h0);
        pipe(1, 0, 5'd9, 64'h0, 64'h9F);
        step();
        chk("waw_pw_waddr", 64'(rf_waddr), 64'd9);
        chk("waw_pw_wdata", rf_wdata, 64'h9F);
        pipe(0, 0, 5'd0, 64'h0, 64'h0);
        step();
        chk("waw_no_write", 64'(rf_we), 64'd0);
        chk("waw_count", 64'(fifo_count), 64'd0);
        step();

        // Reset mid-operation with two queued results.
        pipe(1, 0, 5'd20, 64'h0, 64'h20);
        ll(1, 5'd21, 64'h21);
        step();
        pipe(1, 0, 5'd22, 64'h0, 64'h22);
        ll(1, 5'd23, 64'h23);
        step();
        pipe(0, 0, 5'd0, 64'h0, 64'h0);
        ll(0, 5'd0, 64'h0);
        chk("mid_count2", 64'(fifo_count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        chk("mid_rst_wdata", rf_wdata, 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_stall", 64'(pipe_stall), 64'd0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_we", 64'(rf_we), 64'd0);
        end
        chk("post_rst_ready", 64'(ll_ready), 64'd1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
